// File: rtl/stack_ctrl.sv
// Push/pop stack controller driving a single-port combinational-read ram.
// Optional peek operation enabled by defining STACK_PEEK_EN.
module stack_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_push,
`ifdef STACK_PEEK_EN
  input  logic              op_peek,
`endif
  input  logic [WIDTH-1:0]  op_data,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_we,
  input  logic [WIDTH-1:0]  ram_dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, RESP} state_t;

  state_t state, next_state;
  logic   peek;
  logic   peek_q;
  logic   accept;
  logic   is_push;
  logic   op_err;

`ifdef STACK_PEEK_EN
  assign peek = op_peek;
`else
  assign peek = 1'b0;
`endif

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign accept  = op_valid && (state == IDLE);
  // Peek overrides push and behaves as a non-destructive pop.
  assign is_push = op_push && !peek;
  assign op_err  = is_push ? full : empty;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and state-decoded handshake/ram strobes
  always_comb begin
    next_state = state;
    op_ready   = 1'b0;
    ram_we     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (op_err)       next_state = RESP;
          else if (is_push) next_state = PUSH_WR;
          else              next_state = POP_RD;
        end
      end
      PUSH_WR: begin
        ram_we     = 1'b1;
        next_state = RESP;
      end
      POP_RD:  next_state = RESP;
      RESP: begin
        rsp_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: ram address/data set up on accept so they are stable in PUSH_WR/POP_RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      peek_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err <= op_err;
            if (!op_err) begin
              peek_q <= peek;
              if (is_push) begin
                ram_addr <= count[ADDR_W-1:0];
                ram_din  <= op_data;
              end else begin
                ram_addr <= ADDR_W'(count - CW'(1));
              end
            end
          end
        end
        PUSH_WR: count <= count + CW'(1);
        POP_RD: begin
          rsp_data <= ram_dout;
          if (!peek_q) count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural combinational-read ram.
// Peek steps are included when STACK_PEEK_EN is defined.
module tb_stack_ctrl;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic              op_push = 1'b0;
  logic              op_peek = 1'b0;
  logic [WIDTH-1:0]  op_data = '0;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din;
  logic              ram_we;
  logic [WIDTH-1:0]  ram_dout;

  logic [WIDTH-1:0]  mem [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_push  (op_push),
`ifdef STACK_PEEK_EN
    .op_peek  (op_peek),
`endif
    .op_data  (op_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op, then follow it until rsp_valid, recording latency and ram activity.
  task automatic run_op(input logic push, input logic peek, input logic [WIDTH-1:0] d,
                        output int lat, output int we_cyc, output logic [ADDR_W-1:0] a0,
                        output logic [ADDR_W-1:0] wa, output logic [WIDTH-1:0] wd,
                        output logic err, output logic [WIDTH-1:0] rd);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    op_valid = 1'b1;
    op_push  = push;
    op_peek  = peek;
    op_data  = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_push  = 1'b1;
    op_peek  = 1'b0;
    op_data  = WIDTH'($urandom);
    lat = 0; we_cyc = 0; a0 = ram_addr; wa = '0; wd = '0;
    while (!rsp_valid && lat < 10) begin
      if (ram_we) begin
        we_cyc++;
        wa = ram_addr;
        wd = ram_din;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    err = rsp_err;
    rd  = rsp_data;
  endtask

  initial begin
    int lat, we_cyc, bad;
    logic [ADDR_W-1:0] a0, wa;
    logic [WIDTH-1:0]  wd, rd;
    logic err;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("idle_ready", 32'(op_ready), 32'd1);

    // Single push
    run_op(1'b1, 1'b0, 16'h1234, lat, we_cyc, a0, wa, wd, err, rd);
    chk("push1_lat", 32'(lat), 32'd1);
    chk("push1_we_cycles", 32'(we_cyc), 32'd1);
    chk("push1_addr", 32'(wa), 32'd0);
    chk("push1_din", 32'(wd), 32'h1234);
    chk("push1_err", 32'(err), 32'd0);
    chk("push1_count", 32'(count), 32'd1);
    chk("push1_empty", 32'(empty), 32'd0);
    chk("push1_rsp_data_held", 32'(rd), 32'd0);
    chk("push1_mem0", 32'(mem[0]), 32'h1234);
    @(posedge clk); #1;
    chk("push1_rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // Two pushes then two pops (LIFO order)
    do_reset();
    run_op(1'b1, 1'b0, 16'hAAAA, lat, we_cyc, a0, wa, wd, err, rd);
    run_op(1'b1, 1'b0, 16'hBBBB, lat, we_cyc, a0, wa, wd, err, rd);
    chk("push2_addr", 32'(wa), 32'd1);
    chk("push2_count", 32'(count), 32'd2);
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("pop1_lat", 32'(lat), 32'd1);
    chk("pop1_addr", 32'(a0), 32'd1);
    chk("pop1_data", 32'(rd), 32'hBBBB);
    chk("pop1_err", 32'(err), 32'd0);
    chk("pop1_no_we", 32'(we_cyc), 32'd0);
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("pop2_addr", 32'(a0), 32'd0);
    chk("pop2_data", 32'(rd), 32'hAAAA);
    chk("pop2_count", 32'(count), 32'd0);
    chk("pop2_empty", 32'(empty), 32'd1);

    // Underflow
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("under_lat", 32'(lat), 32'd0);
    chk("under_err", 32'(err), 32'd1);
    chk("under_count", 32'(count), 32'd0);
    chk("under_no_we", 32'(we_cyc), 32'd0);
    chk("under_rsp_data_held", 32'(rd), 32'hAAAA);

    // Fill to DEPTH, overflow, then pop the top
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      run_op(1'b1, 1'b0, WIDTH'(i), lat, we_cyc, a0, wa, wd, err, rd);
      if (err !== 1'b0 || wa !== ADDR_W'(i) || we_cyc != 1) bad++;
    end
    chk("fill_all_ok", 32'(bad), 32'd0);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    run_op(1'b1, 1'b0, 16'hFFFF, lat, we_cyc, a0, wa, wd, err, rd);
    chk("over_lat", 32'(lat), 32'd0);
    chk("over_err", 32'(err), 32'd1);
    chk("over_no_we", 32'(we_cyc), 32'd0);
    chk("over_count", 32'(count), 32'(DEPTH));
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("top_addr", 32'(a0), 32'(DEPTH - 1));
    chk("top_data", 32'(rd), 32'(DEPTH - 1));
    chk("top_count", 32'(count), 32'(DEPTH - 1));
    chk("top_full", 32'(full), 32'd0);

    // Reset during PUSH_WR
    do_reset();
    @(negedge clk);
    op_valid = 1'b1;
    op_push  = 1'b1;
    op_data  = 16'h5555;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("abort_we_before", 32'(ram_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_async", 32'(ram_we), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("abort_no_rsp", 32'(bad), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_count_after", 32'(count), 32'd0);
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("abort_pop_err", 32'(err), 32'd1);

`ifdef STACK_PEEK_EN
    // Peek is a non-destructive pop
    run_op(1'b1, 1'b0, 16'h00FF, lat, we_cyc, a0, wa, wd, err, rd);
    run_op(1'b1, 1'b1, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("peek_data", 32'(rd), 32'h00FF);
    chk("peek_err", 32'(err), 32'd0);
    chk("peek_no_we", 32'(we_cyc), 32'd0);
    chk("peek_count", 32'(count), 32'd1);
    run_op(1'b0, 1'b0, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("peek_pop_data", 32'(rd), 32'h00FF);
    chk("peek_pop_count", 32'(count), 32'd0);
    run_op(1'b0, 1'b1, 16'h0, lat, we_cyc, a0, wa, wd, err, rd);
    chk("peek_empty_err", 32'(err), 32'd1);
    chk("peek_empty_lat", 32'(lat), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Initiator-side controller for the single-port `ram` block. Presents a push/pop stack interface to the core, e.g. for the call/return stack.
- Drives `ram_addr`, `ram_din` and `ram_we`, and samples `ram_dout` (combinational read).
- Tracks the stack pointer, full and empty status, and flags overflow/underflow errors.
- One operation in flight at a time, using a valid/ready request and a single-cycle response strobe.

Parameters:
- WIDTH, 16, data word width; must match the attached ram WIDTH.
- ADDR_W, 8, ram address width; stack depth DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  request strobe.
- op_ready  out  1  request accepted when op_valid && op_ready at a posedge.
- op_push  in  1  1 = push, 0 = pop; sampled only on acceptance.
- op_data  in  WIDTH  push data; sampled only on acceptance.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  WIDTH  popped word; holds its value until the next pop/peek response.
- rsp_err  out  1  qualifies rsp_valid: overflow or underflow, no state change.
- count  out  ADDR_W+1  current number of entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ram_addr  out  ADDR_W  address to the ram.
- ram_din  out  WIDTH  write data to the ram.
- ram_we  out  1  ram write enable.
- ram_dout  in  WIDTH  read data from the ram, combinational on ram_addr.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - ram_we=0 immediately; ram_we is decoded from state only.
  - ram_addr=0, ram_din=0.
  - RAM contents are not cleared.
- Reset mid-operation aborts the operation: no response is produced and count returns to 0.
- FSM states: IDLE, PUSH_WR, POP_RD, RESP.
- IDLE:
  - op_ready=1.
  - Accepted push with full=1 -> RESP with rsp_err=1; count unchanged; no ram write.
  - Accepted pop with empty=1 -> RESP with rsp_err=1; count unchanged.
  - Accepted push otherwise -> latch op_data; go to PUSH_WR.
  - Accepted pop otherwise -> go to POP_RD.
- PUSH_WR:
  - op_ready=0.
  - ram_we=1 for exactly this one cycle; ram_addr=count[ADDR_W-1:0]; ram_din=latched data.
  - At the posedge: count<=count+1; go to RESP with rsp_err=0.
- POP_RD:
  - op_ready=0; ram_we=0; ram_addr=count-1.
  - At the posedge: rsp_data<=ram_dout; count<=count-1; go to RESP.
- RESP:
  - op_ready=0; rsp_valid=1 for one cycle; then IDLE.
  - There is no response backpressure.
- Latency, with acceptance at edge N:
  - Valid push/pop: rsp_valid is high in the cycle after edge N+1.
  - Error: rsp_valid is high in the cycle after edge N.
  - Minimum spacing between successive accepts: 3 cycles for valid ops, 2 for errors.
- Outside PUSH_WR and POP_RD: ram_we=0; ram_addr holds its last value.
- full and empty are combinational from count. count never exceeds DEPTH and never wraps below 0.
- Push at count=DEPTH-1 writes address DEPTH-1 and sets full.
- Pop at count=1 reads address 0 and sets empty.
- op_push and op_data are ignored while op_ready=0.

Optional Feature:
- Macro STACK_PEEK_EN.
- Defined:
  - Adds input port op_peek (1 bit).
  - An accepted op with op_peek=1 overrides op_push and goes through POP_RD without changing count.
  - rsp_data gets the top entry (address count-1).
  - Peek on an empty stack gives rsp_err=1.
- Undefined: the op_peek port is absent; only push and pop exist.

Test Plan:
- Reset, then push 0x1234 -> ram_we high for exactly one cycle, addr=0, din=0x1234; rsp_valid=1, rsp_err=0; count=1, empty=0.
- Push 0xAAAA, 0xBBBB, then pop twice -> rsp_data=0xBBBB then 0xAAAA; ram_addr=1 then 0; count returns to 0; empty=1.
- Pop when empty -> rsp_valid one cycle after accept with rsp_err=1; count=0; no ram_we pulse.
- Fill with DEPTH pushes (values equal to their index) -> full=1 and count=DEPTH; the next push gives rsp_err=1 and no write; the following pop returns DEPTH-1.
- Assert rst during PUSH_WR -> ram_we falls asynchronously; no rsp_valid; count=0 after reset. A subsequent pop returns rsp_err=1.
- With STACK_PEEK_EN defined: push 0x00FF, then peek -> rsp_data=0x00FF and count stays 1; a following pop also returns 0x00FF.
